pooling_stream_unit: RTL and testbench
======================================

Name: pooling_stream_unit

Overview:
- Parametrised successor of the single-shot pooling block: reduces SIZE×SIZE pooling windows for LANES channels in parallel.
- Receives one window element per lane per beat, so a window arrives as SIZE*SIZE beats.
- Supports runtime max or average mode, valid/ready handshakes on both sides, and a synchronous window abort.
- Sits between the activation/quantise stage and the next layer's input feature-map buffer.

Parameters:
- LANES, 16, channels processed in parallel (one IFM_BIT element per lane per beat).
- IFM_BIT, 8, unsigned activation width; also the output element width.
- SIZE, 2, window edge (1..4); window length N = SIZE*SIZE beats.
- CNT_W, 16, width of the completed-window counter.

Ports:
- clk, input, 1, single clock, all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous abort of any partial window and any held output.
- mode, input, 1, 0 = max pooling, 1 = average pooling; sampled on the first beat of each window.
- in_valid, input, 1, activation beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- activation, input, LANES*IFM_BIT, lane k at bits [k*IFM_BIT +: IFM_BIT], unsigned.
- out_valid, output, 1, pooled result valid.
- out_ready, input, 1, consumer accepts the result.
- pooling, output, LANES*IFM_BIT, pooled result, same lane packing as activation.
- win_cnt, output, CNT_W, number of windows delivered (out_valid && out_ready); wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, beat counter=0, all accumulators=0, out_valid=0, pooling=0, win_cnt=0.
- A beat is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- in_ready = (state != OUT) || out_ready. This allows the first beat of the next window in the same cycle the current result is delivered.
- FSM states: IDLE, ACC, OUT.
  - IDLE: on an accepted beat, latch mode into mode_r, load acc[k] = element k, set cnt=1, go to ACC. If N==1, go directly to OUT with the result computed from that beat.
  - ACC: on each accepted beat, acc[k] = max(acc[k], elem) when mode_r=0, or acc[k] + elem when mode_r=1; cnt++. When the accepted beat is beat N (cnt==N-1 before the update), register the result into pooling, set out_valid=1, go to OUT. Cycles with no beat hold all state.
  - OUT: pooling and out_valid hold stable until delivery. On delivery, win_cnt++. If a first beat is also accepted in that cycle, take the IDLE first-beat actions (go to ACC, or to OUT again when N==1). Otherwise go to IDLE and set out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the last beat; pooling is registered (combinational into the register, no extra cycle).
- Accumulator width is IFM_BIT + ceil(log2(N)). Max mode uses only the low IFM_BIT bits.
- Average result = (sum + N/2) / N, integer division, round half up. The result never exceeds 2^IFM_BIT-1, so no saturation logic is needed. The divider is a constant divisor. N=1 passes data through; power-of-two N reduces to add-and-shift.
- mode changing mid-window has no effect until the next first beat.
- clear=1: state → IDLE, cnt=0, out_valid=0; win_cnt unchanged. Any in_valid beat in that cycle is dropped; in_ready is still computed normally, but the beat is discarded. clear takes priority over all other events.
- win_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid and activation are don't-care when not accepted. X on activation outside accepted beats must not propagate to pooling.

Test Plan:
- Reset and idle: assert rst for 5 cycles with in_valid=0 -> out_valid=0, pooling=0, win_cnt=0, in_ready=1; no out_valid within 100 cycles.
- Max, SIZE=2, LANES=16: lane 0 beats 3, 200, 17, 199 and all other lanes 1, 2, 3, 4, mode=0, out_ready=1 -> one cycle with out_valid; lane 0 = 200, others = 4; win_cnt=1.
- Average rounding, SIZE=2: lane 0 beats 1, 2, 2, 2 (sum 7) -> (7+2)/4 = 2; lane 1 beats 255×4 -> 255; lane 2 beats 0, 0, 0, 2 -> 1. mode=1.
- Backpressure: complete a window with out_ready=0 for 10 cycles -> out_valid and pooling stable, in_ready=0, extra in_valid beats not accepted. Then raise out_ready together with in_valid -> result delivered and new window's first beat accepted in the same cycle; win_cnt increments once.
- Gaps and mode latch: SIZE=3 window with in_valid bubbles between beats, mode toggled from 0 to 1 after beat 2 -> max result from 9 beats; out_valid only after the 9th accepted beat.
- Clear and wrap: clear after 2 of 4 beats -> IDLE; the next 4-beat window yields a result from only those 4 beats. Deliver 2^CNT_W windows (CNT_W=4, i.e. 16) -> win_cnt returns to 0. Assert rst mid-ACC -> immediate out_valid=0 and state IDLE.

Source files
------------

// File: rtl/pooling_stream_unit.sv
// Streaming SIZExSIZE max/average pooling over LANES channels, one element per lane per beat.
// The pooled result is registered on the same edge that accepts the last beat of a window.

module pooling_lane #(
   parameter int IFM_BIT = 8,
   parameter int N       = 4,
   parameter int ACC_W   = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_last,
   input  logic               i_mode,
   input  logic [IFM_BIT-1:0] i_elem,
   output logic [IFM_BIT-1:0] o_pool
);
   localparam logic [ACC_W-1:0] C_HALF = ACC_W'(N / 2);

   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   w_elem;
   logic [ACC_W-1:0]   w_nxt;
   logic [ACC_W-1:0]   w_rnd;
   logic [IFM_BIT-1:0] w_max;
   logic [IFM_BIT-1:0] w_avg;
   logic [IFM_BIT-1:0] w_res;

   assign w_elem = ACC_W'(i_elem);
   assign w_max  = (r_acc[IFM_BIT-1:0] > i_elem) ? r_acc[IFM_BIT-1:0] : i_elem;

   // The first beat of a window overwrites whatever the previous window left behind.
   always_comb begin
      w_nxt = w_elem;
      if (!i_load) begin
         if (i_mode) w_nxt = r_acc + w_elem;
         else        w_nxt = ACC_W'(w_max);
      end
   end

   // Sum plus N/2 cannot exceed ACC_W bits, and the quotient always fits IFM_BIT.
   assign w_rnd = w_nxt + C_HALF;

   generate
      if ((N & (N - 1)) == 0) begin : g_shift
         localparam int SH = $clog2(N);
         assign w_avg = IFM_BIT'(w_rnd >> SH);
      end else begin : g_div
         localparam logic [ACC_W-1:0] C_N = ACC_W'(N);
         assign w_avg = IFM_BIT'(w_rnd / C_N);
      end
   endgenerate

   assign w_res = i_mode ? w_avg : w_nxt[IFM_BIT-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc  <= '0;
         o_pool <= '0;
      end else begin
         if (i_load || i_step) r_acc <= w_nxt;
         if (i_last)           o_pool <= w_res;
      end
   end
endmodule

module pooling_stream_unit #(
   parameter int LANES   = 16,
   parameter int IFM_BIT = 8,
   parameter int SIZE    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_mode,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [LANES*IFM_BIT-1:0] i_activation,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [LANES*IFM_BIT-1:0] o_pooling,
   output logic [CNT_W-1:0]         o_win_cnt
);
   localparam int N     = SIZE * SIZE;
   localparam int ACC_W = IFM_BIT + $clog2(N);
   localparam int BC_W  = $clog2(N + 1);
   localparam logic [BC_W-1:0] C_LAST = BC_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

   state_t           r_state;
   logic [BC_W-1:0]  r_cnt;
   logic             r_mode;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_win_cnt;

   logic w_accept;
   logic w_first;
   logic w_step;
   logic w_last;
   logic w_deliver;
   logic w_mode_eff;

   // A held result may leave in the same cycle the next window's first beat arrives.
   assign o_in_ready  = (r_state != S_OUT) || i_out_ready;
   assign o_out_valid = r_out_valid;
   assign o_win_cnt   = r_win_cnt;

   assign w_accept   = i_in_valid && o_in_ready && !i_clear;
   assign w_deliver  = r_out_valid && i_out_ready && !i_clear;
   assign w_first    = w_accept && (r_state != S_ACC);
   assign w_step     = w_accept && (r_state == S_ACC);
   assign w_last     = w_first ? (N == 1) : (w_step && (r_cnt == C_LAST));
   assign w_mode_eff = w_first ? i_mode : r_mode;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         pooling_lane #(
            .IFM_BIT (IFM_BIT),
            .N       (N),
            .ACC_W   (ACC_W)
         ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_load (w_first),
            .i_step (w_step),
            .i_last (w_last),
            .i_mode (w_mode_eff),
            .i_elem (i_activation[g*IFM_BIT +: IFM_BIT]),
            .o_pool (o_pooling[g*IFM_BIT +: IFM_BIT])
         );
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_out_valid <= 1'b0;
         r_win_cnt   <= '0;
      end else if (i_clear) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_deliver) r_win_cnt <= r_win_cnt + CNT_W'(1);
         if (w_first) begin
            r_mode <= i_mode;
            if (N == 1) begin
               r_state     <= S_OUT;
               r_out_valid <= 1'b1;
               r_cnt       <= '0;
            end else begin
               r_state     <= S_ACC;
               r_out_valid <= 1'b0;
               r_cnt       <= BC_W'(1);
            end
         end else if (w_step) begin
            if (w_last) begin
               r_state     <= S_OUT;
               r_out_valid <= 1'b1;
               r_cnt       <= '0;
            end else begin
               r_cnt <= r_cnt + BC_W'(1);
            end
         end else if (w_deliver) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pooling_stream_unit.sv
// Bench for pooling_stream_unit: a 2x2/16-lane instance and a 3x3/4-lane instance, both with a 4-bit window counter.
module tb_pooling_stream_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst, a_clear, a_mode, a_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [127:0] a_act, a_pool;
   logic [3:0]   a_cnt;
   logic         b_rst, b_clear, b_mode, b_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0]  b_act, b_pool;
   logic [3:0]   b_cnt;

   int checks = 0;
   int errors = 0;
   int expA_cnt = 0;
   int expB_cnt = 0;
   logic [127:0] qA[$];
   logic [31:0]  qB[$];

   pooling_stream_unit #(.LANES(16), .IFM_BIT(8), .SIZE(2), .CNT_W(4)) u_dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_clear(a_clear), .i_mode(a_mode),
      .i_in_valid(a_valid), .o_in_ready(a_in_ready), .i_activation(a_act),
      .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_pooling(a_pool),
      .o_win_cnt(a_cnt));

   pooling_stream_unit #(.LANES(4), .IFM_BIT(8), .SIZE(3), .CNT_W(4)) u_dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_clear(b_clear), .i_mode(b_mode),
      .i_in_valid(b_valid), .o_in_ready(b_in_ready), .i_activation(b_act),
      .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_pooling(b_pool),
      .o_win_cnt(b_cnt));

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] a_ref(input logic [3:0][127:0] b, input bit md);
      logic [127:0] r;
      int s, m, v;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         s = 0; m = 0;
         for (int j = 0; j < 4; j++) begin
            v = int'(b[j][k*8 +: 8]);
            s += v;
            if (v > m) m = v;
         end
         r[k*8 +: 8] = md ? 8'((s + 2) / 4) : 8'(m);
      end
      return r;
   endfunction

   function automatic logic [31:0] b_ref(input logic [8:0][31:0] b, input bit md);
      logic [31:0] r;
      int s, m, v;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         s = 0; m = 0;
         for (int j = 0; j < 9; j++) begin
            v = int'(b[j][k*8 +: 8]);
            s += v;
            if (v > m) m = v;
         end
         r[k*8 +: 8] = md ? 8'((s + 4) / 9) : 8'(m);
      end
      return r;
   endfunction

   task automatic a_beat(input logic [127:0] act, input bit md);
      int t;
      t = 0;
      a_valid = 1'b1; a_act = act; a_mode = md; #1;
      while (!a_in_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!a_in_ready) begin
         checks++; errors++;
         $display("FAIL a_beat_ready: in_ready=%0b required 1", a_in_ready);
      end
      @(posedge clk); @(negedge clk);
      a_valid = 1'b0; a_act = r128();
   endtask

   task automatic b_beat(input logic [31:0] act, input bit md);
      int t;
      t = 0;
      b_valid = 1'b1; b_act = act; b_mode = md; #1;
      while (!b_in_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!b_in_ready) begin
         checks++; errors++;
         $display("FAIL b_beat_ready: in_ready=%0b required 1", b_in_ready);
      end
      @(posedge clk); @(negedge clk);
      b_valid = 1'b0; b_act = $urandom;
   endtask

   task automatic a_window(input logic [3:0][127:0] b, input bit md);
      qA.push_back(a_ref(b, md));
      for (int j = 0; j < 4; j++) a_beat(b[j], md);
   endtask

   task automatic a_wait(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (a_out_valid) found = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic b_wait(output bit found);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (b_out_valid) found = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bit seen;
      a_rst = 1; b_rst = 1; a_clear = 0; b_clear = 0; a_mode = 0; b_mode = 0;
      a_valid = 0; b_valid = 0; a_out_ready = 0; b_out_ready = 0;
      a_act = '0; b_act = '0;
      repeat (5) @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0 || a_pool !== '0 || a_cnt !== 4'd0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_a: valid=%0b pool=%h cnt=%0d ready=%0b required 0/0/0/1",
                  a_out_valid, a_pool, a_cnt, a_in_ready);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_pool !== '0 || b_cnt !== 4'd0 || b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_b: valid=%0b pool=%h cnt=%0d ready=%0b required 0/0/0/1",
                  b_out_valid, b_pool, b_cnt, b_in_ready);
      end
      a_rst = 0; b_rst = 0; seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_out_valid || b_out_valid) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL idle_valid: out_valid seen=1 required 0"); end
   endtask

   task automatic test_max();
      logic [3:0][127:0] b;
      logic [127:0] exp;
      logic [7:0] l0 [4];
      logic [7:0] o;
      bit f;
      l0[0] = 8'd3; l0[1] = 8'd200; l0[2] = 8'd17; l0[3] = 8'd199;
      for (int j = 0; j < 4; j++) begin
         o = 8'(j + 1);
         b[j] = {{15{o}}, l0[j]};
      end
      a_out_ready = 1;
      a_window(b, 1'b0);
      a_wait(f);
      exp = qA.pop_front();
      checks++;
      if (!f || a_pool !== exp) begin
         errors++; $display("FAIL max_result: valid=%0b got %h required %h", f, a_pool, exp);
      end
      checks++;
      if (a_pool[7:0] !== 8'd200 || a_pool[15:8] !== 8'd4) begin
         errors++; $display("FAIL max_lanes: got %0d/%0d required 200/4", a_pool[7:0], a_pool[15:8]);
      end
      expA_cnt++;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0 || a_cnt !== 4'(expA_cnt)) begin
         errors++;
         $display("FAIL max_once: valid=%0b cnt=%0d required 0/%0d", a_out_valid, a_cnt, expA_cnt % 16);
      end
   endtask

   task automatic test_avg();
      logic [3:0][127:0] b;
      logic [127:0] exp;
      logic [7:0] l0 [4];
      logic [7:0] l2 [4];
      bit f;
      l0[0] = 8'd1; l0[1] = 8'd2; l0[2] = 8'd2; l0[3] = 8'd2;
      l2[0] = 8'd0; l2[1] = 8'd0; l2[2] = 8'd0; l2[3] = 8'd2;
      for (int j = 0; j < 4; j++) begin
         b[j] = r128();
         b[j][7:0] = l0[j]; b[j][15:8] = 8'd255; b[j][23:16] = l2[j];
      end
      a_window(b, 1'b1);
      a_wait(f);
      exp = qA.pop_front();
      checks++;
      if (!f || a_pool !== exp) begin
         errors++; $display("FAIL avg_result: valid=%0b got %h required %h", f, a_pool, exp);
      end
      checks++;
      if (a_pool[7:0] !== 8'd2 || a_pool[15:8] !== 8'd255 || a_pool[23:16] !== 8'd1) begin
         errors++;
         $display("FAIL avg_round: got %0d/%0d/%0d required 2/255/1",
                  a_pool[7:0], a_pool[15:8], a_pool[23:16]);
      end
      expA_cnt++;
      @(negedge clk);
      checks++;
      if (a_cnt !== 4'(expA_cnt)) begin
         errors++; $display("FAIL avg_cnt: got %0d required %0d", a_cnt, expA_cnt % 16);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0][127:0] b, nb;
      logic [127:0] exp, held;
      bit f, md, nm, bad;
      for (int j = 0; j < 4; j++) begin b[j] = r128(); nb[j] = r128(); end
      md = 1'($urandom); nm = ~md;
      a_out_ready = 0;
      a_window(b, md);
      a_wait(f);
      exp = qA.pop_front();
      held = a_pool;
      checks++;
      if (!f || a_pool !== exp) begin
         errors++; $display("FAIL bp_result: valid=%0b got %h required %h", f, a_pool, exp);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         a_valid = 1; a_act = r128(); #1;
         if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_pool !== held) bad = 1;
         @(negedge clk);
      end
      checks++;
      if (bad || a_cnt !== 4'(expA_cnt)) begin
         errors++; $display("FAIL bp_hold: unstable=%0b cnt=%0d required 0/%0d", bad, a_cnt, expA_cnt % 16);
      end
      qA.push_back(a_ref(nb, nm));
      a_valid = 1; a_act = nb[0]; a_mode = nm; a_out_ready = 1; #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready: got %0b required 1", a_in_ready);
      end
      @(posedge clk); @(negedge clk);
      a_valid = 0;
      expA_cnt++;
      checks++;
      if (a_out_valid !== 1'b0 || a_cnt !== 4'(expA_cnt)) begin
         errors++;
         $display("FAIL bp_overlap: valid=%0b cnt=%0d required 0/%0d", a_out_valid, a_cnt, expA_cnt % 16);
      end
      for (int j = 1; j < 4; j++) a_beat(nb[j], md);
      a_wait(f);
      exp = qA.pop_front();
      checks++;
      if (!f || a_pool !== exp) begin
         errors++; $display("FAIL bp_next: valid=%0b got %h required %h", f, a_pool, exp);
      end
      expA_cnt++;
      @(negedge clk);
   endtask

   task automatic test_gaps_mode();
      logic [8:0][31:0] bb;
      logic [31:0] exp;
      bit f, early;
      for (int j = 0; j < 9; j++) bb[j] = $urandom;
      b_out_ready = 1;
      qB.push_back(b_ref(bb, 1'b0));
      early = 0;
      for (int j = 0; j < 9; j++) begin
         b_beat(bb[j], j >= 2);
         if (j < 8) begin
            if (b_out_valid) early = 1;
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               if (b_out_valid) early = 1;
            end
         end
      end
      checks++;
      if (early) begin errors++; $display("FAIL gap_early: out_valid before beat 9 = 1 required 0"); end
      b_wait(f);
      exp = qB.pop_front();
      checks++;
      if (!f || b_pool !== exp) begin
         errors++; $display("FAIL gap_max: valid=%0b got %h required %h", f, b_pool, exp);
      end
      expB_cnt++;
      @(negedge clk);
      checks++;
      if (b_cnt !== 4'(expB_cnt) || b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_cnt: cnt=%0d valid=%0b required %0d/0", b_cnt, b_out_valid, expB_cnt % 16);
      end
   endtask

   task automatic test_clear();
      logic [3:0][127:0] sb, hb;
      logic [127:0] exp;
      bit f, early;
      a_out_ready = 1;
      a_beat({16{8'd250}}, 1'b0);
      a_beat({16{8'd249}}, 1'b0);
      a_clear = 1; a_valid = 1; a_act = {16{8'd251}};
      @(posedge clk); @(negedge clk);
      a_clear = 0; a_valid = 0;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_cnt !== 4'(expA_cnt)) begin
         errors++;
         $display("FAIL clear_idle: valid=%0b ready=%0b cnt=%0d required 0/1/%0d",
                  a_out_valid, a_in_ready, a_cnt, expA_cnt % 16);
      end
      for (int j = 0; j < 4; j++) sb[j] = r128() & {16{8'h7f}};
      qA.push_back(a_ref(sb, 1'b0));
      a_beat(sb[0], 1'b0);
      a_beat(sb[1], 1'b0);
      early = a_out_valid;
      a_beat(sb[2], 1'b0);
      early = early | a_out_valid;
      a_beat(sb[3], 1'b0);
      checks++;
      if (early) begin errors++; $display("FAIL clear_partial: early out_valid=1 required 0"); end
      a_wait(f);
      exp = qA.pop_front();
      checks++;
      if (!f || a_pool !== exp) begin
         errors++; $display("FAIL clear_result: valid=%0b got %h required %h", f, a_pool, exp);
      end
      expA_cnt++;
      @(negedge clk);
      a_out_ready = 0;
      for (int j = 0; j < 4; j++) hb[j] = r128();
      a_window(hb, 1'b1);
      a_wait(f);
      exp = qA.pop_front();
      a_clear = 1;
      @(posedge clk); @(negedge clk);
      a_clear = 0;
      checks++;
      if (!f || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_cnt !== 4'(expA_cnt)) begin
         errors++;
         $display("FAIL clear_held: seen=%0b valid=%0b ready=%0b cnt=%0d required 1/0/1/%0d",
                  f, a_out_valid, a_in_ready, a_cnt, expA_cnt % 16);
      end
      a_out_ready = 1;
   endtask

   task automatic test_back_to_back_wrap();
      logic [3:0][127:0] b;
      logic [127:0] exp;
      bit f;
      a_out_ready = 1;
      while (expA_cnt % 16 != 0) begin
         for (int j = 0; j < 4; j++) b[j] = r128();
         a_window(b, 1'($urandom));
         a_wait(f);
         exp = qA.pop_front();
         checks++;
         if (!f || a_pool !== exp) begin
            errors++; $display("FAIL b2b_result: win=%0d got %h required %h", expA_cnt, a_pool, exp);
         end
         expA_cnt++;
      end
      @(negedge clk);
      checks++;
      if (a_cnt !== 4'd0 || expA_cnt < 16) begin
         errors++; $display("FAIL wrap_cnt: got %0d after %0d windows required 0", a_cnt, expA_cnt);
      end
   endtask

   task automatic test_rst_mid();
      logic [8:0][31:0] bb;
      logic [31:0] exp;
      bit f, early;
      for (int j = 0; j < 9; j++) bb[j] = $urandom;
      b_out_ready = 0;
      for (int j = 0; j < 9; j++) b_beat(bb[j], 1'b1);
      b_wait(f);
      b_rst = 1; #1;
      checks++;
      if (!f || b_out_valid !== 1'b0 || b_pool !== '0 || b_cnt !== 4'd0) begin
         errors++;
         $display("FAIL rst_held: seen=%0b valid=%0b pool=%h cnt=%0d required 1/0/0/0",
                  f, b_out_valid, b_pool, b_cnt);
      end
      @(negedge clk);
      b_rst = 0; expB_cnt = 0; b_out_ready = 1;
      for (int j = 0; j < 4; j++) b_beat($urandom, 1'b0);
      b_rst = 1; #1;
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_acc: valid=%0b ready=%0b required 0/1", b_out_valid, b_in_ready);
      end
      @(negedge clk);
      b_rst = 0;
      qB.push_back(b_ref(bb, 1'b0));
      early = 0;
      for (int j = 0; j < 9; j++) begin
         b_beat(bb[j], 1'b0);
         if (j < 8 && b_out_valid) early = 1;
      end
      b_wait(f);
      exp = qB.pop_front();
      checks++;
      if (early || !f || b_pool !== exp) begin
         errors++;
         $display("FAIL rst_next: early=%0b valid=%0b got %h required %h", early, f, b_pool, exp);
      end
      expB_cnt++;
      @(negedge clk);
      checks++;
      if (b_cnt !== 4'(expB_cnt)) begin
         errors++; $display("FAIL rst_cnt: got %0d required %0d", b_cnt, expB_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_avg();
      test_backpressure();
      test_gaps_mode();
      test_clear();
      test_back_to_back_wrap();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
